// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU encodings, FSM states and IR field positions shared by the fetch/decode stage.
// Opcode 0xFF is HALT only when HALT_OPCODE_EN is defined.
package cpu_pkg;
    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_HALT  = 8'hFF;
    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam int OP_LO = 24;
    localparam int RD_LO = 16;
    localparam int RT_LO = 8;
    localparam int RS_LO = 0;
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;
endpackage

// File: rtl/instr_fetch_decode_if.sv
// instr_fetch_decode_if: instruction-memory handshake, downstream status and decode outputs.
interface instr_fetch_decode_if #(parameter int PC_W = 32, parameter int RF_AW = 3);
    logic             IMEM_READ;
    logic [PC_W-1:0]  IMEM_ADDR;
    logic             IMEM_BUSYWAIT;
    logic [31:0]      IMEM_INSTR;
    logic             STALL;
    logic             ZERO;
    logic [RF_AW-1:0] INADDRESS;
    logic [RF_AW-1:0] OUT1ADDRESS;
    logic [RF_AW-1:0] OUT2ADDRESS;
    logic             WRITE;
    logic [7:0]       IMMEDIATE;
    logic [2:0]       ALUOP;
    logic             IMM_SEL;
    logic             NEG_SEL;
    logic [PC_W-1:0]  PC;
    logic             ILLEGAL;
    modport master (
        output IMEM_READ, IMEM_ADDR, INADDRESS, OUT1ADDRESS, OUT2ADDRESS, WRITE,
               IMMEDIATE, ALUOP, IMM_SEL, NEG_SEL, PC, ILLEGAL,
        input  IMEM_BUSYWAIT, IMEM_INSTR, STALL, ZERO
    );
    modport slave (
        input  IMEM_READ, IMEM_ADDR, INADDRESS, OUT1ADDRESS, OUT2ADDRESS, WRITE,
               IMMEDIATE, ALUOP, IMM_SEL, NEG_SEL, PC, ILLEGAL,
        output IMEM_BUSYWAIT, IMEM_INSTR, STALL, ZERO
    );
endinterface

// File: rtl/instr_decoder.sv
// instr_decoder: combinational opcode decode into ALU controls, write type and control-flow flags.
// With HALT_OPCODE_EN defined, 0xFF decodes as halt instead of illegal.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] op,
    output logic [2:0] aluop,
    output logic       imm_sel,
    output logic       neg_sel,
    output logic       wr,
    output logic       illegal,
    output logic       jump,
    output logic       branch,
    output logic       halt
);
    always_comb begin
        aluop = ALU_FWD;
        imm_sel = 1'b0;
        neg_sel = 1'b0;
        wr = 1'b0;
        illegal = 1'b0;
        jump = 1'b0;
        branch = 1'b0;
        halt = 1'b0;
        case (op)
            OP_LOADI: begin imm_sel = 1'b1; wr = 1'b1; end
            OP_MOV:   wr = 1'b1;
            OP_ADD:   begin aluop = ALU_ADD; wr = 1'b1; end
            OP_SUB:   begin aluop = ALU_ADD; neg_sel = 1'b1; wr = 1'b1; end
            OP_AND:   begin aluop = ALU_AND; wr = 1'b1; end
            OP_OR:    begin aluop = ALU_OR; wr = 1'b1; end
            OP_J:     jump = 1'b1;
            OP_BEQ:   begin aluop = ALU_ADD; neg_sel = 1'b1; branch = 1'b1; end
`ifdef HALT_OPCODE_EN
            OP_HALT:  halt = 1'b1;
`endif
            default:  illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: PC, IR and FETCH/EXEC(/HALT) control ahead of the register file.
// HALT_OPCODE_EN adds the HALT state reached through opcode 0xFF.
module instr_fetch_decode
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              RF_AW    = 3,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic                   CLK,
    input logic                   RESET,
    instr_fetch_decode_if.master  bus
);
    state_t          state, next;
    logic [31:0]     ir;
    logic [PC_W-1:0] pc, pc_inc, target, next_pc;
    logic [2:0]      aluop;
    logic            imm_sel, neg_sel, wr, illegal, jump, branch, halt, exec, unused;

    instr_decoder u_dec (
        .op(ir[OP_LO +: 8]), .aluop(aluop), .imm_sel(imm_sel), .neg_sel(neg_sel), .wr(wr),
        .illegal(illegal), .jump(jump), .branch(branch), .halt(halt)
    );

    assign exec    = state == S_EXEC;
    assign pc_inc  = pc + PC_W'(4);
    assign target  = pc_inc + {{(PC_W-10){ir[RD_LO+7]}}, ir[RD_LO +: 8], 2'b00};
    assign next_pc = (jump || (branch && bus.ZERO)) ? target : pc_inc;
    assign unused  = ^ir[15:11];

    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) state <= S_FETCH;
        else state <= next;

    always_comb begin
        next = state;
        if (state == S_FETCH && !bus.IMEM_BUSYWAIT) next = S_EXEC;
        if (exec && !bus.STALL) next = halt ? S_HALT : S_FETCH;
    end

    // a halting instruction leaves the PC on itself
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            pc <= RESET_PC & ~PC_W'(3);
            ir <= '0;
        end else begin
            if (state == S_FETCH && !bus.IMEM_BUSYWAIT) ir <= bus.IMEM_INSTR;
            if (exec && !bus.STALL && !halt) pc <= next_pc;
        end

    always_comb begin
        bus.IMEM_READ   = RESET && state == S_FETCH;
        bus.IMEM_ADDR   = pc;
        bus.PC          = pc;
        bus.INADDRESS   = ir[RD_LO +: RF_AW];
        bus.OUT1ADDRESS = ir[RT_LO +: RF_AW];
        bus.OUT2ADDRESS = ir[RS_LO +: RF_AW];
        bus.IMMEDIATE   = ir[RS_LO +: 8];
        bus.WRITE       = exec && wr;
        bus.ALUOP       = exec ? aluop : ALU_FWD;
        bus.IMM_SEL     = exec && imm_sel;
        bus.NEG_SEL     = exec && neg_sel;
        bus.ILLEGAL     = exec && illegal && !bus.STALL;
    end
endmodule
